// File: rtl/array8_spst_mult_pipe3.sv
// Unsigned 8x8 array multiplier, 3-stage pipeline, one product per clock.
// Define SPST_GATING_EN to gate zero operands and zero upper nibbles.
module array8_spst_mult_pipe3 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o,
   output logic        valid_o
);

   logic        r_v1;
   logic        r_v2;
   logic        r_v3;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [11:0] r_lo;
   logic [15:0] r_hi;
   logic [15:0] r_p;
   logic [7:0]  w_am;
   logic [11:0] w_lo;
   logic [15:0] w_hi;

`ifdef SPST_GATING_EN
   logic        r_z;
   logic        r_ah0;
   logic        r_bh0;
   logic        r_hz;
   logic        w_za;
   logic        w_zb;
   logic        w_ah0;
   logic        w_bh0;

   assign w_za  = (a_i == 8'd0);
   assign w_zb  = (b_i == 8'd0);
   assign w_ah0 = (a_i[7:4] == 4'd0);
   assign w_bh0 = (b_i[7:4] == 4'd0);

   // Zero operands freeze the array inputs; zero nibbles freeze upper bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_a   <= 8'd0;
         r_b   <= 8'd0;
         r_z   <= 1'b0;
         r_ah0 <= 1'b0;
         r_bh0 <= 1'b0;
      end else begin
         r_v1 <= en;
         if (en) begin
            r_z   <= w_za | w_zb;
            r_ah0 <= w_ah0;
            r_bh0 <= w_bh0;
            if (!(w_za | w_zb)) begin
               r_a[3:0] <= a_i[3:0];
               r_b[3:0] <= b_i[3:0];
               if (!w_ah0) r_a[7:4] <= a_i[7:4];
               if (!w_bh0) r_b[7:4] <= b_i[7:4];
            end
         end
      end
   end

   assign w_am = r_ah0 ? {4'd0, r_a[3:0]} : r_a;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_a  <= 8'd0;
         r_b  <= 8'd0;
      end else begin
         r_v1 <= en;
         if (en) begin
            r_a <= a_i;
            r_b <= b_i;
         end
      end
   end

   assign w_am = r_a;
`endif

   // Partial-product rows summed as two half arrays.
   always_comb begin
      w_lo = 12'd0;
      w_hi = 16'd0;
      for (int i = 0; i < 4; i++) begin
         if (r_b[i]) w_lo = w_lo + ({4'd0, w_am} << i);
      end
      for (int i = 4; i < 8; i++) begin
         if (r_b[i]) w_hi = w_hi + ({8'd0, w_am} << i);
      end
   end

`ifdef SPST_GATING_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2 <= 1'b0;
         r_lo <= 12'd0;
         r_hi <= 16'd0;
         r_hz <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            if (r_z) begin
               r_lo <= 12'd0;
               r_hi <= 16'd0;
               r_hz <= 1'b0;
            end else begin
               r_lo <= w_lo;
               r_hz <= r_bh0;
               if (!r_bh0) r_hi <= w_hi;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2 <= 1'b0;
         r_lo <= 12'd0;
         r_hi <= 16'd0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_lo <= w_lo;
            r_hi <= w_hi;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v3 <= 1'b0;
         r_p  <= 16'd0;
      end else begin
         r_v3 <= r_v2;
         if (r_v2) begin
`ifdef SPST_GATING_EN
            r_p <= {4'd0, r_lo} + (r_hz ? 16'd0 : r_hi);
`else
            r_p <= {4'd0, r_lo} + r_hi;
`endif
         end
      end
   end

   assign p_o     = r_p;
   assign valid_o = r_v3;

endmodule

// File: tb/tb_array8_spst_mult_pipe3.sv
// Bench for array8_spst_mult_pipe3: vector table, hand sequences,
// exhaustive sweep and random stream against a delay-line model.
module tb_array8_spst_mult_pipe3;

   typedef struct {
      logic        v;
      logic [15:0] p;
   } slot_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic [7:0]  a_i;
   logic [7:0]  b_i;
   logic [15:0] p_o;
   logic        valid_o;

   int checks;
   int errors;
   slot_t pipe[$];
   logic [15:0] m_p;
   logic        m_v;

   array8_spst_mult_pipe3 dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .a_i     (a_i),
      .b_i     (b_i),
      .p_o     (p_o),
      .valid_o (valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      slot_t s;
      s.v = 1'b0;
      s.p = 16'd0;
      pipe.delete();
      pipe.push_back(s);
      pipe.push_back(s);
      m_p = 16'd0;
      m_v = 1'b0;
   endtask

   // Drive one pair, clock once, compare against the model.
   task automatic step(input logic e, input logic [7:0] a,
                       input logic [7:0] b);
      slot_t s;
      slot_t o;
      en  = e;
      a_i = a;
      b_i = b;
      @(posedge clk);
      s.v = e;
      s.p = 16'(int'(a) * int'(b));
      pipe.push_back(s);
      o = pipe.pop_front();
      m_v = o.v;
      if (o.v) m_p = o.p;
      #1;
      chk("valid", {15'd0, valid_o}, {15'd0, m_v});
      chk("prod", p_o, m_p);
   endtask

   vec_t tbl[8];

   initial begin
      checks = 0;
      errors = 0;
      tbl[0] = '{8'd15,  8'd10,  16'd150};
      tbl[1] = '{8'd255, 8'd1,   16'd255};
      tbl[2] = '{8'd12,  8'd12,  16'd144};
      tbl[3] = '{8'd200, 8'd3,   16'd600};
      tbl[4] = '{8'd8,   8'd25,  16'd200};
      tbl[5] = '{8'd100, 8'd100, 16'd10000};
      tbl[6] = '{8'd255, 8'd255, 16'd65025};
      tbl[7] = '{8'd7,   8'd13,  16'd91};

      rst = 1'b1;
      en  = 1'b0;
      a_i = 8'd0;
      b_i = 8'd0;
      model_reset();
      #1;
      chk("rst_p", p_o, 16'd0);
      chk("rst_v", {15'd0, valid_o}, 16'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 0*0 then 1*1 back to back; first pair accepted right after reset
      step(1'b1, 8'd0, 8'd0);
      step(1'b1, 8'd1, 8'd1);
      step(1'b0, 8'd0, 8'd0);
      chk("first_v", {15'd0, valid_o}, 16'd1);
      chk("first_p", p_o, 16'd0);
      step(1'b0, 8'd0, 8'd0);
      chk("second_v", {15'd0, valid_o}, 16'd1);
      chk("second_p", p_o, 16'd1);
      step(1'b0, 8'd0, 8'd0);
      chk("drain_v", {15'd0, valid_o}, 16'd0);
      chk("drain_hold", p_o, 16'd1);

      // table stream, one pair per clock
      for (int i = 0; i < 10; i++) begin
         if (i < 8) step(1'b1, tbl[i].a, tbl[i].b);
         else       step(1'b0, 8'd0, 8'd0);
         if (i >= 2) begin
            chk("tbl_v", {15'd0, valid_o}, 16'd1);
            chk("tbl_p", p_o, tbl[i-2].exp);
         end
      end
      repeat (3) step(1'b0, 8'd0, 8'd0);

      // bubble: 8*25, gap, 7*13
      step(1'b1, 8'd8, 8'd25);
      step(1'b0, 8'd99, 8'd99);
      step(1'b1, 8'd7, 8'd13);
      chk("bub1_v", {15'd0, valid_o}, 16'd1);
      chk("bub1_p", p_o, 16'd200);
      step(1'b0, 8'd0, 8'd0);
      chk("bub2_v", {15'd0, valid_o}, 16'd0);
      chk("bub2_p", p_o, 16'd200);
      step(1'b0, 8'd0, 8'd0);
      chk("bub3_v", {15'd0, valid_o}, 16'd1);
      chk("bub3_p", p_o, 16'd91);

      // async reset with three pairs in flight
      step(1'b1, 8'd9, 8'd9);
      step(1'b1, 8'd10, 8'd10);
      step(1'b1, 8'd11, 8'd11);
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_p", p_o, 16'd0);
      chk("arst_v", {15'd0, valid_o}, 16'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'd0, 8'd0);
         chk("post_rst_v", {15'd0, valid_o}, 16'd0);
      end

      // exhaustive sweep, full throughput
      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 256; b++)
            step(1'b1, 8'(a), 8'(b));

      // random stream with random bubbles
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      repeat (3) step(1'b0, 8'd0, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
